// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file write-back path.
//   XLEN     : result / RF write data width
//   NREG     : architectural register count
//   REG_AW   : register address width
//   LQ_DEPTH : default load-result buffer depth
//   wb_req_t : one write-back request (destination + data)
package cpu_pkg;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int REG_AW   = $clog2(NREG);
    localparam int LQ_DEPTH = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Small FIFO holding load results that lost write-port arbitration.
// Ports:
//   clk, rst_n   clock / async active-low reset (flushes the FIFO)
//   i_push       enqueue i_push_req at the tail
//   i_pop        dequeue the head (caller guarantees non-empty)
//   o_head       head entry (valid when !o_empty)
//   o_count      number of stored entries
//   o_empty      count == 0
module wb_load_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  wb_req_t       i_push_req,
    input  logic          i_pop,
    output wb_req_t       o_head,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t        mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;

    // Pointers wrap explicitly so non-power-of-two depths work too.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (i_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (i_push) mem_q[wr_ptr_q] <= i_push_req;
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_empty = (count_q == '0);

endmodule

// File: rtl/reg_writeback.sv
// Write-side master of the register file: arbitrates ALU and load results
// onto the single RF write port and tracks pending destinations for decode
// hazard detection.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   i_issue_valid, i_issue_rd      instruction with destination issued
//   i_alu_valid/rd/data            ALU result (no backpressure)
//   i_lsu_valid/rd/data, o_lsu_ready  load result handshake
//   i_rs1, i_rs2, o_rs1_busy, o_rs2_busy  decode hazard lookup
//   o_we, o_waddr, o_wdata         registered RF write port
// Priority: ALU > buffered load > direct (bypass) load.
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int LQ_DEPTH = cpu_pkg::LQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issue_valid,
    input  logic [REG_AW-1:0] i_issue_rd,
    input  logic              i_alu_valid,
    input  logic [REG_AW-1:0] i_alu_rd,
    input  logic [XLEN-1:0]   i_alu_data,
    input  logic              i_lsu_valid,
    input  logic [REG_AW-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]   i_lsu_data,
    output logic              o_lsu_ready,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy,
    output logic              o_we,
    output logic [REG_AW-1:0] o_waddr,
    output logic [XLEN-1:0]   o_wdata
);

    localparam int CW = $clog2(LQ_DEPTH + 1);

    logic              we_q,    we_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0]   mask_q,  mask_d;

    wb_req_t        head;
    wb_req_t        lsu_req;
    wb_req_t        sel_req;
    logic [CW-1:0]  lq_count;
    logic           lq_empty;
    logic           lq_push;
    logic           lq_pop;
    logic           lsu_acc;
    logic           sel_valid;
    logic           bypass;

    assign lsu_req = '{rd: i_lsu_rd, data: i_lsu_data};

    wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (lq_push),
        .i_push_req (lsu_req),
        .i_pop      (lq_pop),
        .o_head     (head),
        .o_count    (lq_count),
        .o_empty    (lq_empty)
    );

    // Ready depends only on registered occupancy, so a full buffer refuses
    // a load even in a cycle where it is also being popped.
    assign o_lsu_ready = (lq_count < CW'(LQ_DEPTH));
    assign lsu_acc     = i_lsu_valid && o_lsu_ready;

    always_comb begin
        sel_valid = 1'b0;
        sel_req   = '0;
        lq_pop    = 1'b0;
        bypass    = 1'b0;
        if (i_alu_valid) begin
            sel_valid = 1'b1;
            sel_req   = '{rd: i_alu_rd, data: i_alu_data};
        end else if (!lq_empty) begin
            sel_valid = 1'b1;
            sel_req   = head;
            lq_pop    = 1'b1;
        end else if (lsu_acc) begin
            sel_valid = 1'b1;
            sel_req   = lsu_req;
            bypass    = 1'b1;
        end
        lq_push = lsu_acc && !bypass;

        // x0 results are consumed without touching the write port.
        we_d    = sel_valid && (sel_req.rd != '0);
        waddr_d = we_d ? sel_req.rd   : waddr_q;
        wdata_d = we_d ? sel_req.data : wdata_q;
    end

    // Clear on the RF write edge first so a same-edge issue of that rd wins.
    always_comb begin
        mask_d = mask_q;
        if (we_q) mask_d[waddr_q] = 1'b0;
        if (i_issue_valid && (i_issue_rd != '0)) mask_d[i_issue_rd] = 1'b1;
        mask_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
        end
    end

    assign o_we       = we_q;
    assign o_waddr    = waddr_q;
    assign o_wdata    = wdata_q;
    assign o_rs1_busy = mask_q[i_rs1];
    assign o_rs2_busy = mask_q[i_rs2];

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_issue_valid = 1'b0;
    logic [4:0]  i_issue_rd = '0;
    logic        i_alu_valid = 1'b0;
    logic [4:0]  i_alu_rd = '0;
    logic [31:0] i_alu_data = '0;
    logic        i_lsu_valid = 1'b0;
    logic [4:0]  i_lsu_rd = '0;
    logic [31:0] i_lsu_data = '0;
    logic        o_lsu_ready;
    logic [4:0]  i_rs1 = '0;
    logic [4:0]  i_rs2 = '0;
    logic        o_rs1_busy;
    logic        o_rs2_busy;
    logic        o_we;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;

    reg_writeback dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .i_alu_valid   (i_alu_valid),
        .i_alu_rd      (i_alu_rd),
        .i_alu_data    (i_alu_data),
        .i_lsu_valid   (i_lsu_valid),
        .i_lsu_rd      (i_lsu_rd),
        .i_lsu_data    (i_lsu_data),
        .o_lsu_ready   (o_lsu_ready),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .o_rs1_busy    (o_rs1_busy),
        .o_rs2_busy    (o_rs2_busy),
        .o_we          (o_we),
        .o_waddr       (o_waddr),
        .o_wdata       (o_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [4:0] rd; logic [31:0] data; } ld_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } exp_t;

    // Reference model state: buffered loads, expected RF writes, pending mask.
    ld_t        mq[$];
    exp_t       exp_q[$];
    bit [31:0]  m_mask;
    bit         selprev_v, wvis_v, iprev_v;
    logic [4:0] selprev_rd, wvis_rd, iprev_rd;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    // Monitor: every RF write must match the next expected write, in cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    n_cmp++; n_bad++;
                    $display("FAIL missed_write @cyc %0d: got no write expected rd=%0d data=%0h",
                             cyc, exp_q[0].rd, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                if (o_we) begin
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                        n_cmp++; n_bad++;
                        $display("FAIL spurious_write @cyc %0d: got rd=%0d data=%0h expected none",
                                 cyc, o_waddr, o_wdata);
                    end else begin
                        chk("waddr", 32'(o_waddr), 32'(exp_q[0].rd));
                        chk("wdata", o_wdata, exp_q[0].data);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] adata,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ldata,
                        input bit iv_in, input logic [4:0] ird,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit rnd, output bit acc);
        bit iv, ready, sv, bp;
        ld_t s;
        // Effects of the edge that just passed.
        if (wvis_v) m_mask[wvis_rd] = 1'b0;
        if (iprev_v && iprev_rd != 0) m_mask[iprev_rd] = 1'b1;
        wvis_v  = selprev_v;
        wvis_rd = selprev_rd;

        iv = iv_in;
        if (rnd && iv && ird != 0 && m_mask[ird]) iv = 1'b0;
        assert (!(iv && ird != 0 && m_mask[ird])) else $error("WAW issue to pending rd %0d", ird);

        ready = (mq.size() < 2);
        i_alu_valid = av;  i_alu_rd = ard;  i_alu_data = adata;
        i_lsu_valid = lv;  i_lsu_rd = lrd;  i_lsu_data = ldata;
        i_issue_valid = iv; i_issue_rd = ird;
        i_rs1 = rs1; i_rs2 = rs2;

        acc = lv && ready;
        bp  = !av && (mq.size() == 0) && acc;
        sv  = 1'b0;
        s   = '{rd: 5'd0, data: 32'd0};
        if (av) begin
            sv = 1'b1; s = '{rd: ard, data: adata};
        end else if (mq.size() > 0) begin
            sv = 1'b1; s = mq.pop_front();
        end else if (acc) begin
            sv = 1'b1; s = '{rd: lrd, data: ldata};
        end
        if (acc && !bp) mq.push_back('{rd: lrd, data: ldata});
        selprev_v  = sv && (s.rd != 0);
        selprev_rd = s.rd;
        if (selprev_v) exp_q.push_back('{rd: s.rd, data: s.data, cyc: cyc + 1});
        iprev_v  = iv;
        iprev_rd = ird;

        @(negedge clk);
        chk("lsu_ready", 32'(o_lsu_ready), 32'(ready));
        chk("rs1_busy", 32'(o_rs1_busy), 32'(m_mask[rs1]));
        chk("rs2_busy", 32'(o_rs2_busy), 32'(m_mask[rs2]));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] rs1);
        bit a;
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, rs1, 5'($urandom_range(0, 31)), 0, a);
    endtask

    task automatic do_reset(input logic [4:0] rs1);
        rst_n = 1'b0;
        i_alu_valid = 0; i_lsu_valid = 0; i_issue_valid = 0;
        i_rs1 = rs1; i_rs2 = 5'd0;
        mq.delete(); exp_q.delete();
        m_mask = '0; selprev_v = 0; wvis_v = 0; iprev_v = 0;
        #1;
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_lsu_ready", 32'(o_lsu_ready), 32'd1);
        chk("rst_rs1_busy", 32'(o_rs1_busy), 32'd0);
        chk("rst_waddr", 32'(o_waddr), 32'd0);
        chk("rst_wdata", o_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit a;
        bit         h_v;
        logic [4:0] h_rd;
        logic [31:0] h_d;
        int ld_i;
        logic [4:0]  bp_rd[3];
        logic [31:0] bp_d[3];

        #3;
        do_reset(5'd5);

        // ALU only: write at N+1, nothing at N+2 (monitor flags a spurious write).
        step(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, a);
        idle(3, 0);

        // Collision: ALU wins, load follows next cycle.
        step(1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007, 0, 0, 0, 0, 0, a);
        chk("collision_acc", 32'(a), 32'd1);
        idle(3, 0);

        // Backpressure: ALU busy 5 cycles, three loads held until accepted.
        bp_rd[0] = 5'd11; bp_rd[1] = 5'd12; bp_rd[2] = 5'd13;
        bp_d[0] = 32'hD00D_0011; bp_d[1] = 32'hD00D_0012; bp_d[2] = 32'hD00D_0013;
        ld_i = 0;
        for (int c = 0; c < 12; c++) begin
            step(c < 5, 5'(20 + c), 32'hA0 + 32'(c), ld_i < 3,
                 (ld_i < 3) ? bp_rd[ld_i] : 5'd0, (ld_i < 3) ? bp_d[ld_i] : 32'd0,
                 0, 0, 0, 0, 0, a);
            if (a) ld_i++;
        end
        chk("backpressure_all_loads", 32'(ld_i), 32'd3);

        // Scoreboard: issue rd9, busy from next cycle, cleared after the write.
        step(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd9, 0, a);
        idle(2, 5'd9);
        step(1, 5'd9, 32'h99, 0, 0, 0, 0, 0, 5'd9, 5'd0, 0, a);
        idle(3, 5'd9);

        // x0: neither issue nor write touches anything.
        step(1, 5'd0, 32'hFFFF, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, a);
        idle(3, 0);

        // Randomized traffic.
        h_v = 0; h_rd = 0; h_d = 0;
        for (int c = 0; c < 800; c++) begin
            if (!h_v && ($urandom_range(0, 1) == 1)) begin
                h_v = 1; h_rd = 5'($urandom_range(0, 31)); h_d = $urandom;
            end
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                 h_v, h_rd, h_d,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1, a);
            if (a) h_v = 0;
        end
        idle(6, 0);

        // Async reset with the buffer full and rd12 pending.
        step(1, 5'd1, 32'h1, 1, 5'd14, 32'h14, 1, 5'd12, 0, 0, 0, a);
        step(1, 5'd2, 32'h2, 1, 5'd15, 32'h15, 0, 0, 5'd12, 0, 0, a);
        i_alu_valid = 0; i_lsu_valid = 0; i_issue_valid = 0; i_rs1 = 5'd12;
        #1;
        chk("pre_rst_ready", 32'(o_lsu_ready), 32'd0);
        chk("pre_rst_busy12", 32'(o_rs1_busy), 32'd1);
        chk("pre_rst_we", 32'(o_we), 32'd1);
        do_reset(5'd12);
        idle(4, 5'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
